// File: rtl/uart_tx_framer.sv
// uart_tx_framer
// Serial transmit engine for the UART datapath. Accepts one parallel word per
// Transmit_Start request and sends it on Tx as a frame:
//   start (0), data MSB-first, optional even parity, STOP_BITS stop bits (1).
// Every bit is held for CLKS_PER_BIT cycles of Clk.
//
// Optional feature: define UART_TX_BREAK_EN to add the Send_Break input, which
// holds Tx low for one full frame time to signal a line break.
//
// Ports:
//   Clk            clock, all logic on posedge
//   Rst            synchronous reset, active low
//   Tx_Data        word to send, sampled only when a request is accepted
//   Transmit_Start level request to send Tx_Data
//   CTS            high = peer ready; gates acceptance only
//   Send_Break     (UART_TX_BREAK_EN only) request a break frame
//   Tx             serial line, idles high
//   Tx_Busy        high while a frame is on the line
//   Tx_Done        one-cycle pulse when a frame completes
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line high, waiting for an armed request
// S_START  | start bit (Tx low)
// S_DATA   | data bits, MSB first
// S_PARITY | even parity bit (only when PARITY_BIT = 1)
// S_STOP   | stop bits (Tx high)
// S_BREAK  | break condition, Tx low for TX_BITS bit periods

module uart_tx_framer #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_BIT   = 1,
  parameter int STOP_BITS    = 2,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATA_BITS-1:0] Tx_Data,
  input  logic                 Transmit_Start,
  input  logic                 CTS,
`ifdef UART_TX_BREAK_EN
  input  logic                 Send_Break,
`endif
  output logic                 Tx,
  output logic                 Tx_Busy,
  output logic                 Tx_Done
);

  localparam int TX_BITS = 1 + DATA_BITS + PARITY_BIT + STOP_BITS;
  localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W   = $clog2(TX_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_q;
  logic                 armed;

  logic baud_last;
  logic brk_req;
  logic req_low;

`ifdef UART_TX_BREAK_EN
  assign brk_req = Send_Break;
`else
  assign brk_req = 1'b0;
`endif

  assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  // A request (data or break) must be seen low once before another is taken,
  // so a level held high through a frame yields only one frame.
  assign req_low   = !Transmit_Start && !brk_req;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      parity_q  <= 1'b0;
      armed     <= 1'b1;
      Tx        <= 1'b1;
      Tx_Busy   <= 1'b0;
      Tx_Done   <= 1'b0;
    end else begin
      Tx_Done <= 1'b0;
      if (req_low) armed <= 1'b1;

      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          // Break has priority and ignores CTS.
          if (armed && brk_req) begin
            state   <= S_BREAK;
            Tx      <= 1'b0;
            Tx_Busy <= 1'b1;
            armed   <= 1'b0;
          end else if (armed && Transmit_Start && CTS) begin
            shift_reg <= Tx_Data;
            parity_q  <= ^Tx_Data;
            state     <= S_START;
            Tx        <= 1'b0;
            Tx_Busy   <= 1'b1;
            armed     <= 1'b0;
          end
        end

        S_START: begin
          if (baud_last) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            Tx        <= shift_reg[DATA_BITS-1];
            shift_reg <= shift_reg << 1;
            state     <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY_BIT != 0) begin
                state <= S_PARITY;
                Tx    <= parity_q;
              end else begin
                state <= S_STOP;
                Tx    <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + CNT_W'(1);
              Tx        <= shift_reg[DATA_BITS-1];
              shift_reg <= shift_reg << 1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        S_PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_STOP;
            Tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        S_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == CNT_W'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= S_IDLE;
              Tx      <= 1'b1;
              Tx_Busy <= 1'b0;
              Tx_Done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        S_BREAK: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == CNT_W'(TX_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= S_IDLE;
              Tx      <= 1'b1;
              Tx_Busy <= 1'b0;
              Tx_Done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          state   <= S_IDLE;
          Tx      <= 1'b1;
          Tx_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer. Two instances share clock and reset:
//   dut0 uses default parameters (8 data, parity, 2 stop, 1 clk/bit)
//   dut1 uses CLKS_PER_BIT=4, PARITY_BIT=0, STOP_BITS=1
// Expected line values come from a frame model indexed by cycle number.

module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data0, data1;
  logic       start0, start1;
  logic       cts0, cts1;
  logic       brk0, brk1;
  logic       tx0, tx1, busy0, busy1, done0, done1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_framer dut0 (
    .Clk(clk), .Rst(rst), .Tx_Data(data0), .Transmit_Start(start0), .CTS(cts0),
`ifdef UART_TX_BREAK_EN
    .Send_Break(brk0),
`endif
    .Tx(tx0), .Tx_Busy(busy0), .Tx_Done(done0)
  );

  uart_tx_framer #(.DATA_BITS(8), .PARITY_BIT(0), .STOP_BITS(1), .CLKS_PER_BIT(4)) dut1 (
    .Clk(clk), .Rst(rst), .Tx_Data(data1), .Transmit_Start(start1), .CTS(cts1),
`ifdef UART_TX_BREAK_EN
    .Send_Break(brk1),
`endif
    .Tx(tx1), .Tx_Busy(busy1), .Tx_Done(done1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic get_tx(int sel);   return (sel != 0) ? tx1 : tx0;     endfunction
  function automatic logic get_busy(int sel); return (sel != 0) ? busy1 : busy0; endfunction
  function automatic logic get_done(int sel); return (sel != 0) ? done1 : done0; endfunction

  task automatic set_start(int sel, logic v); if (sel != 0) start1 = v; else start0 = v; endtask
  task automatic set_cts(int sel, logic v);   if (sel != 0) cts1 = v;   else cts0 = v;   endtask
  task automatic set_data(int sel, logic [7:0] v); if (sel != 0) data1 = v; else data0 = v; endtask

  function automatic int cpb_of(int sel);    return (sel != 0) ? 4 : 1; endfunction
  function automatic int parity_of(int sel); return (sel != 0) ? 0 : 1; endfunction
  function automatic int stop_of(int sel);   return (sel != 0) ? 1 : 2; endfunction
  function automatic int frame_cycles(int sel);
    return (1 + 8 + parity_of(sel) + stop_of(sel)) * cpb_of(sel);
  endfunction

  // Line level k cycles after acceptance for word d.
  function automatic logic exp_bit(int sel, logic [7:0] d, int k);
    int b;
    b = k / cpb_of(sel);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[8 - b];
    if (parity_of(sel) != 0 && b == 9) return ^d;
    return 1'b1;
  endfunction

  // Requests a frame at the next edge and checks it cycle by cycle. When b2b
  // is set it returns right at the Tx_Done cycle so the caller can request
  // again with the minimum idle gap.
  task automatic run_frame(int sel, logic [7:0] d, bit hold, bit cts_drop, bit data_chg, bit b2b);
    int n;
    n = frame_cycles(sel);
    set_data(sel, d);
    set_cts(sel, 1'b1);
    set_start(sel, 1'b1);
    @(negedge clk);
    if (!hold) set_start(sel, 1'b0);
    for (int k = 0; k < n; k++) begin
      check_val("tx_bit", get_tx(sel), exp_bit(sel, d, k));
      check_val("busy_in_frame", get_busy(sel), 1'b1);
      check_val("done_in_frame", get_done(sel), 1'b0);
      if (k == n / 2) begin
        if (cts_drop) set_cts(sel, 1'b0);
        if (data_chg) set_data(sel, ~d);
      end
      @(negedge clk);
    end
    check_val("busy_end", get_busy(sel), 1'b0);
    check_val("done_pulse", get_done(sel), 1'b1);
    check_val("tx_end", get_tx(sel), 1'b1);
    if (!b2b) begin
      @(negedge clk);
      check_val("done_low", get_done(sel), 1'b0);
      check_val("tx_idle", get_tx(sel), 1'b1);
    end
  endtask

  task automatic check_idle(int sel, string tag);
    check_val(tag, get_tx(sel), 1'b1);
    check_val(tag, get_busy(sel), 1'b0);
    check_val(tag, get_done(sel), 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    data0 = 8'h00; data1 = 8'h00;
    start0 = 1'b1; start1 = 1'b1;  // request during reset must not start a frame
    cts0 = 1'b1; cts1 = 1'b1;
    brk0 = 1'b0; brk1 = 1'b0;

    repeat (3) @(negedge clk);
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    repeat (2) @(negedge clk);
    check_idle(0, "post_reset0");
    check_idle(1, "post_reset1");

    // Basic data frame
    run_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

    // CTS gating: request waits while CTS is low
    cts0 = 1'b0;
    start0 = 1'b1;
    data0 = 8'h5A;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle(0, "cts_wait");
    end
    run_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);

    // Re-arm: held request gives exactly one frame
    run_frame(0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_idle(0, "held_no_refire");
    end
    start0 = 1'b0;
    @(negedge clk);
    run_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

    // Slow, no-parity, single-stop variant with mid-frame data change
    run_frame(1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back frames with the minimum idle gap
    run_frame(0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame during data bit 3 of 8'hFF
    data0 = 8'hFF; cts0 = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_val("pre_rst_tx", tx0, exp_bit(0, 8'hFF, k));
      @(negedge clk);
    end
    check_val("pre_rst_busy", busy0, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_idle(0, "mid_reset");
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check_idle(0, "abandoned");
    end
    run_frame(0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized frames against the model
    for (int i = 0; i < 10; i++) begin
      int sel;
      logic [7:0] d;
      sel = int'($urandom_range(0, 1));
      d = 8'($urandom);
      run_frame(sel, d, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    @(negedge clk);
    check_idle(0, "final_idle0");
    check_idle(1, "final_idle1");

`ifdef UART_TX_BREAK_EN
    // Break: one-cycle request with CTS low
    cts0 = 1'b0;
    brk0 = 1'b1;
    @(negedge clk);
    brk0 = 1'b0;
    for (int k = 0; k < frame_cycles(0); k++) begin
      check_val("brk_tx", tx0, 1'b0);
      check_val("brk_busy", busy0, 1'b1);
      @(negedge clk);
    end
    check_val("brk_busy_end", busy0, 1'b0);
    check_val("brk_done", done0, 1'b1);
    check_val("brk_tx_end", tx0, 1'b1);
    @(negedge clk);
    check_idle(0, "brk_idle");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
